pixel_writer: RTL and testbench

Downstream video stage of the DPU. It captures 24-bit pixel words ({X, Y, Colour}, taken from DPU registers 9/10/11 when video output is enabled) into a small FIFO. Each queued pixel is converted to a linear framebuffer address and written to the framebuffer memory port with a request/acknowledge handshake. It decouples DPU video-out bursts from a framebuffer that may stall.

---
 rtl/pixel_writer.sv | 120 ++++++++++++
 tb/tb_pixel_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// pixel_writer: queues 24-bit {X,Y,Colour} pixel words in a small FIFO and
// writes each one to a linear framebuffer with a we/ack handshake.
// Optional feature macro: PIXWR_CLIP_EN (drop and count off-screen pixels).
module pixel_writer #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] Kbus,
   input  logic        pix_valid,
   output logic        in_ready,
   output logic [15:0] fb_addr,
   output logic [7:0]  fb_data,
   output logic        fb_we,
   input  logic        fb_ack,
   output logic        busy,
   output logic        overflow,
   output logic [7:0]  clip_cnt
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, CALC, WRITE} state_e;

   state_e        state_q, state_d;
   logic [23:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   logic [23:0]   pix_q;
   logic [15:0]   fb_addr_q;
   logic [7:0]    fb_data_q;
   logic          overflow_q;
   logic          push, pop, clip;

   // Head is popped only from IDLE; a pop frees a slot for a same-cycle push.
   assign pop      = (state_q == IDLE) && (count_q != '0);
   assign in_ready = (count_q != (PW+1)'(DEPTH)) || pop;
   assign push     = pix_valid && in_ready;

`ifdef PIXWR_CLIP_EN
   logic [7:0] clip_cnt_q;
   assign clip = ({1'b0, pix_q[23:16]} >= 9'(SCREEN_W)) ||
                 ({1'b0, pix_q[15:8]}  >= 9'(SCREEN_H));

   // Saturating count of pixels dropped in CALC for being off-screen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                clip_cnt_q <= '0;
      else if (state_q == CALC && clip && clip_cnt_q != 8'hFF) clip_cnt_q <= clip_cnt_q + 8'd1;
   end
   assign clip_cnt = clip_cnt_q;
`else
   assign clip     = 1'b0;
   assign clip_cnt = '0;
`endif

   // FIFO storage; no reset needed, validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= Kbus;
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (pix_valid && !in_ready) overflow_q <= 1'b1;
      end
   end

   // Popped pixel, then its address/colour resolved in CALC and held through WRITE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_q     <= '0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
      end else begin
         if (pop) pix_q <= mem_q[rd_ptr_q];
         if (state_q == CALC) begin
            fb_addr_q <= 16'(pix_q[15:8]) * 16'(SCREEN_W) + 16'(pix_q[23:16]);
            fb_data_q <= pix_q[7:0];
         end
      end
   end

   // State register; async reset drops fb_we at once since fb_we decodes state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: IDLE -> CALC on pop, CALC -> WRITE (or IDLE if clipped), WRITE -> IDLE on ack.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pop) state_d = CALC;
         CALC:    state_d = clip ? IDLE : WRITE;
         WRITE:   if (fb_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign fb_we    = (state_q == WRITE);
   assign fb_addr  = fb_addr_q;
   assign fb_data  = fb_data_q;
   assign busy     = (count_q != '0) || (state_q != IDLE);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer with a write scoreboard.
module tb_pixel_writer;

   localparam int W = 160;
   localparam int H = 120;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] Kbus = '0;
   logic        pix_valid = 1'b0;
   logic        in_ready;
   logic [15:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_we;
   logic        fb_ack = 1'b0;
   logic        busy;
   logic        overflow;
   logic [7:0]  clip_cnt;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   logic [23:0] sb [$];

   pixel_writer #(.SCREEN_W(W), .SCREEN_H(H), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .Kbus(Kbus), .pix_valid(pix_valid), .in_ready(in_ready),
      .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ack(fb_ack),
      .busy(busy), .overflow(overflow), .clip_cnt(clip_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_addr(input int x, input int y);
      return 16'((y * W + x) % 65536);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one push cycle; the expected write is queued if accepted and on-screen.
   task automatic push(input int x, input int y, input int c, input bit acc);
      bit clipped;
      Kbus      = {8'(x), 8'(y), 8'(c)};
      pix_valid = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(acc));
`ifdef PIXWR_CLIP_EN
      clipped = (x >= W) || (y >= H);
`else
      clipped = 1'b0;
`endif
      if (acc && !clipped) sb.push_back({exp_addr(x, y), 8'(c)});
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1; pix_valid = 1'b0; fb_ack = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      sb.delete();
   endtask

   task automatic wait_writes(input int n, input string tag);
      int budget = 200;
      while (wr_cnt < n && budget > 0) begin step(); budget--; end
      chk(tag, 32'(wr_cnt), 32'(n));
   endtask

   // Scoreboard: each handshake completes a write that must match the queue head.
   always @(negedge clk) begin
      if (!rst && fb_we === 1'b1 && fb_ack === 1'b1) begin
         wr_cnt++;
         if (sb.size() == 0) chk("unexpected_write", {8'h0, fb_addr, fb_data}, 32'hFFFF_FFFF);
         else begin
            logic [23:0] e;
            e = sb.pop_front();
            chk("write_addr_data", {8'h0, fb_addr, fb_data}, {8'h0, e});
         end
      end
   end

   initial begin
      int base;
      do_reset();
      // reset state
      chk("rst_fb_we", 32'(fb_we), 0);
      chk("rst_fb_addr", 32'(fb_addr), 0);
      chk("rst_fb_data", 32'(fb_data), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_clip_cnt", 32'(clip_cnt), 0);

      // single pixel, ack tied high: fb_we rises 3 cycles after the push
      fb_ack = 1'b1;
      base = wr_cnt;
      push(5, 10, 8'h3C, 1'b1);
      pix_valid = 1'b0;
      chk("t1_we_c1", 32'(fb_we), 0);
      step();
      chk("t1_we_c2", 32'(fb_we), 0);
      step();
      chk("t1_we_c3", 32'(fb_we), 1);
      chk("t1_addr", 32'(fb_addr), 1605);
      chk("t1_data", 32'(fb_data), 32'h3C);
      step();
      chk("t1_we_c4", 32'(fb_we), 0);
      repeat (4) step();
      chk("t1_one_write", 32'(wr_cnt - base), 1);
      chk("t1_busy", 32'(busy), 0);

      // burst of 6 with ack held low: 5 accepted, 6th overflows
      do_reset();
      base = wr_cnt;
      for (int i = 0; i < 6; i++) push(i, i + 1, 8'h10 + i, i < 5);
      pix_valid = 1'b0;
      chk("burst_overflow", 32'(overflow), 1);
      chk("burst_in_ready", 32'(in_ready), 0);
      fb_ack = 1'b1;
      wait_writes(base + 5, "burst_writes");
      repeat (6) step();
      chk("burst_no_extra", 32'(wr_cnt - base), 5);
      chk("burst_sb_empty", 32'(sb.size()), 0);
      chk("burst_overflow_sticky", 32'(overflow), 1);

      // delayed ack: outputs hold for 7 cycles, fb_we falls after the ack cycle
      do_reset();
      base = wr_cnt;
      push(7, 3, 8'hA5, 1'b1);
      pix_valid = 1'b0;
      step(); step();
      for (int i = 0; i < 7; i++) begin
         chk("hold_we", 32'(fb_we), 1);
         chk("hold_addr", 32'(fb_addr), 32'(exp_addr(7, 3)));
         chk("hold_data", 32'(fb_data), 32'hA5);
         step();
      end
      chk("hold_no_write_yet", 32'(wr_cnt - base), 0);
      fb_ack = 1'b1;
      chk("ack_cycle_we", 32'(fb_we), 1);
      step();
      fb_ack = 1'b0;
      chk("after_ack_we", 32'(fb_we), 0);
      chk("ack_one_write", 32'(wr_cnt - base), 1);

      // clipping (or plain truncated writes when clipping is compiled out)
      do_reset();
      base = wr_cnt;
      fb_ack = 1'b1;
      push(200, 10, 8'h01, 1'b1);
      push(3, 130, 8'h02, 1'b1);
      push(159, 119, 8'h03, 1'b1);
      pix_valid = 1'b0;
`ifdef PIXWR_CLIP_EN
      wait_writes(base + 1, "clip_writes");
      repeat (8) step();
      chk("clip_cnt", 32'(clip_cnt), 2);
      chk("clip_total_writes", 32'(wr_cnt - base), 1);
`else
      wait_writes(base + 3, "noclip_writes");
      repeat (4) step();
      chk("noclip_cnt", 32'(clip_cnt), 0);
`endif
      chk("clip_sb_empty", 32'(sb.size()), 0);

      // full FIFO with simultaneous push and pop
      do_reset();
      base = wr_cnt;
      for (int i = 0; i < 5; i++) push(20 + i, 2, 8'h40 + i, 1'b1);
      pix_valid = 1'b0;
      chk("full_in_ready", 32'(in_ready), 0);
      fb_ack = 1'b1;
      step();
      fb_ack = 1'b0;
      push(30, 4, 8'h55, 1'b1);
      pix_valid = 1'b0;
      chk("full_still_full", 32'(in_ready), 0);
      chk("full_overflow", 32'(overflow), 0);
      fb_ack = 1'b1;
      wait_writes(base + 6, "full_writes");
      chk("full_sb_empty", 32'(sb.size()), 0);

      // async reset mid-WRITE with 3 pixels queued
      do_reset();
      base = wr_cnt;
      for (int i = 0; i < 4; i++) push(50 + i, 6, 8'h60 + i, 1'b1);
      pix_valid = 1'b0;
      chk("mid_we", 32'(fb_we), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_we", 32'(fb_we), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      sb.delete();
      step();
      rst = 1'b0;
      fb_ack = 1'b1;
      repeat (12) step();
      chk("mid_no_writes", 32'(wr_cnt - base), 0);
      chk("mid_busy", 32'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
